// File: rtl/crc3_pkg.sv
// rtl/crc3_pkg.sv - shared CRC-3 constants, FSM state type and one-bit CRC step
package crc3_pkg;
  localparam int          CRC_W    = 3;
  localparam logic [3:0]  CRC_POLY = 4'b1011;

  typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

  // Serial division step for G = x^3 + x + 1: shift, then fold the low poly terms back in on feedback.
  function automatic logic [CRC_W-1:0] crc3_step(input logic [CRC_W-1:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY[CRC_W-1:0] : '0);
  endfunction
endpackage

// File: rtl/crc3_lfsr.sv
// rtl/crc3_lfsr.sv - 3-bit CRC register: clear, absorb a message bit, or shift the remainder out
module crc3_lfsr
  import crc3_pkg::*;
(
  input  logic             clk,
  input  logic             clrn,
  input  logic             clr,
  input  logic             step,
  input  logic             din,
  input  logic             shift_out,
  output logic [CRC_W-1:0] crc
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)          crc <= '0;
    else if (clr)       crc <= '0;
    else if (step)      crc <= crc3_step(crc, din);
    else if (shift_out) crc <= {crc[CRC_W-2:0], 1'b0};
  end

endmodule

// File: rtl/crc3_tx_framer.sv
// rtl/crc3_tx_framer.sv - serializes a message word MSB first and appends its CRC-3 remainder
// Optional back-to-back framing (no IDLE gap) under CRC3_TX_BACK2BACK_EN.
module crc3_tx_framer
  import crc3_pkg::*;
#(
  parameter int MSG_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [MSG_W-1:0] msg_data,
  input  logic             msg_valid,
  output logic             msg_ready,
  output logic             tx_bit,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_sof,
  output logic             tx_eof
);

  // Counter must hold both MSG_W-1 and the CRC reload value 2.
  localparam int               CNT_W    = (MSG_W > 4) ? $clog2(MSG_W) : 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_W - 1);
  localparam logic [CNT_W-1:0] CNT_CRC  = CNT_W'(CRC_W - 1);

  state_t           state, state_nxt;
  logic [MSG_W-1:0] shift;
  logic [CNT_W-1:0] cnt;
  logic [CRC_W-1:0] crc;
  logic             beat, accept, cnt_zero;

  assign beat     = tx_valid & tx_ready;
  assign accept   = msg_valid & msg_ready;
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DATA;
      DATA:    if (beat && cnt_zero) state_nxt = CRC;
      CRC:     if (beat && cnt_zero) state_nxt = accept ? DATA : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    msg_ready = 1'b0;
    tx_valid  = 1'b0;
    tx_bit    = 1'b0;
    tx_sof    = 1'b0;
    tx_eof    = 1'b0;
    case (state)
      IDLE: msg_ready = 1'b1;
      DATA: begin
        tx_valid = 1'b1;
        tx_bit   = shift[MSG_W-1];
        tx_sof   = (cnt == CNT_LAST);
      end
      CRC: begin
        tx_valid = 1'b1;
        tx_bit   = crc[CRC_W-1];
        tx_eof   = cnt_zero;
`ifdef CRC3_TX_BACK2BACK_EN
        msg_ready = cnt_zero & tx_ready;
`else
        msg_ready = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      shift <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shift <= msg_data;
      cnt   <= CNT_LAST;
    end else if (beat) begin
      if (state == DATA) begin
        shift <= {shift[MSG_W-2:0], 1'b0};
        cnt   <= cnt_zero ? CNT_CRC : cnt - 1'b1;
      end else begin
        cnt   <= cnt_zero ? '0 : cnt - 1'b1;
      end
    end
  end

  crc3_lfsr u_lfsr (
    .clk       (clk),
    .clrn      (clrn),
    .clr       (accept),
    .step      (beat && (state == DATA)),
    .din       (tx_bit),
    .shift_out (beat && (state == CRC)),
    .crc       (crc)
  );

endmodule

// File: doc/crc3_tx_framer.md
Name: crc3_tx_framer

Overview:
- Upstream framing stage for the serial CRC-3 path (G = x^3 + x + 1, divisor 1011).
- Accepts a parallel message word over a valid/ready handshake and serializes it MSB first.
- Computes the CRC-3 remainder on the fly and appends the 3 remainder bits, so every emitted frame is exactly divisible by G.
- Output is a serial bit stream with valid/ready flow control and start/end-of-frame markers, feeding the serial link and the downstream CRC checker.

Parameters:
- MSG_W, 8, message word width in bits; legal range 2..64.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- msg_data  in  MSG_W  parallel message; sampled on accept.
- msg_valid  in  1  upstream word available.
- msg_ready  out  1  framer can accept a word.
- tx_bit  out  1  current serial bit.
- tx_valid  out  1  tx_bit is meaningful.
- tx_ready  in  1  downstream consumes tx_bit this cycle.
- tx_sof  out  1  tx_bit is the first message bit of the frame.
- tx_eof  out  1  tx_bit is the last CRC bit of the frame.

Behaviour:
- Reset (clrn low, asynchronous): state IDLE; shift register, bit counter and CRC register cleared.
  - Reset outputs: msg_ready=1, tx_valid=0, tx_bit=0, tx_sof=0, tx_eof=0.
  - Reset mid-frame abandons the frame; no partial CRC is emitted.
- States: IDLE, DATA, CRC.
- IDLE:
  - msg_ready=1, tx_valid=0.
  - Accept occurs on msg_valid & msg_ready: load shift register with msg_data, clear CRC to 000, load counter with MSG_W-1, go to DATA.
  - Accept-to-first-bit latency is 1 cycle.
- DATA:
  - Outputs: tx_valid=1, tx_bit=shift[MSG_W-1], tx_sof=1 while the counter equals MSG_W-1 (first bit only), msg_ready=0.
  - A beat completes on tx_valid & tx_ready:
    - shift left (zero fill);
    - CRC update with fb = tx_bit ^ crc[2]: crc <= {crc[1], crc[0]^fb, fb};
    - decrement the counter.
  - On the beat where the counter is 0: go to CRC and load the counter with 2.
- CRC:
  - Outputs: tx_valid=1, tx_bit=crc[2], tx_eof=1 when the counter is 0.
  - Each beat: crc <= {crc[1:0], 0}, decrement the counter.
  - On the beat where the counter is 0: go to IDLE.
- Stall (tx_ready=0): every output and all internal state held; tx_bit is stable under backpressure.
- Frame length is MSG_W+3 beats. Minimum frame period is MSG_W+4 cycles, because of one IDLE cycle between frames.
- msg_data is ignored while not accepting. The upstream side must hold msg_data/msg_valid until accepted.
- tx_sof and tx_eof never assert in the same beat (MSG_W ≥ 2).

Optional Feature:
- Macro: CRC3_TX_BACK2BACK_EN.
- Defined:
  - msg_ready is also 1 in CRC while the counter is 0 and tx_ready=1.
  - An accept in that cycle loads the new word and goes directly to DATA (CRC cleared), with no IDLE gap.
  - Minimum frame period becomes MSG_W+3 cycles.
- Undefined: msg_ready=1 only in IDLE.

Decomposition:
- Package crc3_pkg:
  - CRC_W=3;
  - CRC_POLY=4'b1011;
  - state enum {IDLE, DATA, CRC};
  - a function implementing the one-bit CRC step.
- Sub-module crc3_lfsr: the 3-bit register.
  - Inputs: clr, step (data bit), shift_out.
  - Output: crc[2:0].
- The framer owns the FSM, shift register and counter.

Test Plan:
- Reset during DATA (clrn pulse mid-frame) -> asynchronously IDLE, tx_valid=0, msg_ready=1. The next frame for 8'hD3 is correct with no residue.
- msg_data=8'hD3, tx_ready=1 -> tx_bit sequence 1,1,0,1,0,0,1,1,0,1,1 (CRC=011).
  - tx_sof on beat 0, tx_eof on beat 10.
  - msg_ready low for 11 cycles.
- msg_data=8'h00 -> 11 zero bits, CRC 000. msg_data=8'h01 -> last four bits 1,0,1,1.
- 8'hD3 with tx_ready toggled randomly (including a stall on the sof and eof beats) -> identical bit sequence; tx_bit/tx_sof/tx_eof stable while stalled.
- Two words back-to-back, msg_valid held high -> one idle cycle between frames. With CRC3_TX_BACK2BACK_EN defined: the first bit of frame 2 immediately follows frame 1's eof beat.
- Scoreboard over 1000 random words, fed through a serial checker -> every frame remainder is 000.
